// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for the UART transmitter. It latches a parallel byte,
// serializes it LSB first, computes its parity bit, and steers the TX output
// mux so the line carries start, data, optional parity and stop bits in order.
// CLK is the TX bit clock, so every state lasts a whole number of bit periods.
//
// Ports:
//   CLK        in   TX bit clock (one bit period per cycle)
//   RST        in   asynchronous active-low reset
//   P_DATA     in   parallel payload, sampled only when a frame is accepted
//   Data_Valid in   request to send P_DATA
//   PAR_EN     in   1 = append a parity bit (sampled with P_DATA)
//   PAR_TYP    in   0 = even parity, 1 = odd parity (sampled with P_DATA)
//   mux_sel    out  TX mux select: 00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data   out  current payload bit, LSB first
//   par_bit    out  parity bit of the latched payload
//   busy       out  high while a frame is on the line
//
// Handshake: a request is taken when Data_Valid is high at a rising edge while
// the sequencer is in IDLE or STOP. Requests in any other state are dropped,
// not queued. A producer that holds Data_Valid through STOP gets the next
// frame with no idle bit in between, even though busy is still high in STOP.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  accept;
    logic                  last_bit;

    assign accept   = Data_Valid && ((state == IDLE) || (state == STOP));
    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = IDLE;
        mux_sel    = 2'b01;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                mux_sel    = 2'b01;
                busy       = 1'b0;
                state_next = accept ? START : IDLE;
            end
            START: begin
                mux_sel    = 2'b00;
                busy       = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                mux_sel    = 2'b10;
                busy       = 1'b1;
                if (last_bit) begin
                    state_next = par_en_q ? PARITY : STOP;
                end else begin
                    state_next = DATA;
                end
            end
            PARITY: begin
                mux_sel    = 2'b11;
                busy       = 1'b1;
                state_next = STOP;
            end
            STOP: begin
                mux_sel    = 2'b01;
                busy       = 1'b1;
                state_next = accept ? START : IDLE;
            end
            default: begin
                // Unused encodings park the line idle and fall back to IDLE.
                mux_sel    = 2'b01;
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Payload datapath: shift register, bit counter, parity, PAR_EN latch.
    // Everything is captured only on an accepted request, so input changes
    // mid-frame cannot corrupt the frame on the line.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit   <= 1'b0;
        end else if (accept) begin
            shift_reg <= P_DATA;
            bit_cnt   <= '0;
            par_en_q  <= PAR_EN;
            par_bit   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        end else begin
            case (state)
                START: begin
                    bit_cnt <= '0;
                end
                DATA: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                default: begin
                    shift_reg <= shift_reg;
                    bit_cnt   <= bit_cnt;
                end
            endcase
        end
    end

    // The bit on the line is always the LSB; shifting right walks the payload
    // out LSB first.
    assign ser_data = shift_reg[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Self-checking bench for uart_tx_ctrl. A frame-level reference model turns
// each accepted request into the list of line bits it must produce (start,
// payload LSB first, optional parity, stop) and keeps them in exp_q; one entry
// is consumed per bit period and compared with the observed mux select, busy
// and the bit that matters in that period.
//
// Entry encoding: [3:2] mux select, [1] busy, [0] payload bit in a data period,
// parity bit in a parity period, 0 otherwise.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [1:0]   mux_sel;
    logic         ser_data;
    logic         par_bit;
    logic         busy;

    int           errors = 0;
    int           checks = 0;
    logic [3:0]   exp_q[$];
    logic [1:0]   last_mux;

    // ------------------------------------------------------------------
    // Clock and DUT
    // ------------------------------------------------------------------
    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Parity from a plain count of ones: even parity makes the total number
    // of ones (payload + parity) even, odd parity makes it odd.
    function automatic logic parity_of(input logic [W-1:0] d, input logic odd);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        exp_q.push_back({2'b00, 1'b1, 1'b0});
        for (int i = 0; i < W; i++) exp_q.push_back({2'b10, 1'b1, d[i]});
        if (pe) exp_q.push_back({2'b11, 1'b1, parity_of(d, pt)});
        exp_q.push_back({2'b01, 1'b1, 1'b0});
    endtask

    // Drive one bit period: apply inputs, let the model decide whether the
    // request is taken (only when the line was idle or sending stop), clock,
    // then hand back the expected and observed entries for this period.
    task automatic cycle(input logic dv, input logic [W-1:0] d, input logic pe,
                         input logic pt, output logic [3:0] e, output logic [3:0] o);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        if (dv && (last_mux == 2'b01)) push_frame(d, pe, pt);
        else if (exp_q.size() == 0) exp_q.push_back({2'b01, 1'b0, 1'b0});
        @(posedge CLK);
        #1;
        e        = exp_q.pop_front();
        last_mux = e[3:2];
        o        = {mux_sel, busy,
                    (mux_sel == 2'b10) ? ser_data : ((mux_sel == 2'b11) ? par_bit : 1'b0)};
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_mux = 2'b01;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] e, o;
        RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({mux_sel, busy, par_bit, ser_data} !== 5'b01_0_0_0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got mux=%b busy=%b par=%b ser=%b want 01 0 0 0",
                         i, mux_sel, busy, par_bit, ser_data);
            end
        end
        Data_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(i == 0, 8'h5A, 1'b1, 1'b1, e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_frame cyc=%0d got=%b want=%b", i, o, e);
            end
        end
    endtask

    task automatic test_parity_frame();
        logic [3:0] e, o;
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(i == 0, 8'hA5, 1'b1, 1'b0, e, o);
            busy_cycles += int'(busy);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL a5_frame cyc=%0d got=%b want=%b", i, o, e);
            end
        end
        checks++;
        if (busy_cycles !== 11) begin
            errors++;
            $display("FAIL a5_length got=%0d want=11", busy_cycles);
        end
    endtask

    task automatic test_no_parity();
        logic [3:0] e, o;
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 13; i++) begin
            cycle(i == 0, 8'h01, 1'b0, 1'b0, e, o);
            busy_cycles += int'(busy);
            checks++;
            if (o !== e || mux_sel === 2'b11) begin
                errors++;
                $display("FAIL no_parity cyc=%0d got=%b want=%b", i, o, e);
            end
        end
        checks++;
        if (busy_cycles !== 10) begin
            errors++;
            $display("FAIL no_parity_length got=%0d want=10", busy_cycles);
        end
    endtask

    // Odd then even parity of 0x07; PAR_TYP and P_DATA wander mid-frame.
    task automatic test_parity_type();
        logic [3:0] e, o;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 13; i++) begin
                if (i == 0) cycle(1'b1, 8'h07, 1'b1, (f == 0), e, o);
                else        cycle(1'b0, W'($urandom), 1'b1, i[0], e, o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL parity_type f=%0d cyc=%0d got=%b want=%b", f, i, o, e);
                end
            end
        end
    endtask

    // 0x3C frame; 0xFF request pulsed during data bit 3 must be dropped; a
    // request for 0x81 raised in the parity period is held and taken at stop.
    task automatic test_back_to_back();
        logic [3:0] e, o;
        logic       dv;
        logic [W-1:0] d;
        for (int i = 0; i < 26; i++) begin
            dv = (i == 0) || (i == 4) || (i == 10) || (i == 11);
            d  = (i == 0) ? 8'h3C : ((i == 4) ? 8'hFF : 8'h81);
            cycle(dv, d, 1'b1, 1'b0, e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] e, o;
        for (int i = 0; i < 5; i++) cycle(i == 0, 8'hF0, 1'b1, 1'b0, e, o);
        Data_Valid = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({mux_sel, busy, par_bit, ser_data} !== 5'b01_0_0_0) begin
            errors++;
            $display("FAIL reset_mid_frame got mux=%b busy=%b par=%b ser=%b want 01 0 0 0",
                     mux_sel, busy, par_bit, ser_data);
        end
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        for (int i = 0; i < 18; i++) begin
            cycle(i == 5, 8'h96, 1'b0, 1'b0, e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got=%b want=%b", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] e, o;
        logic       dv;
        for (int i = 0; i < 600; i++) begin
            dv = ($urandom_range(0, 3) == 0);
            cycle(dv, W'($urandom), 1'($urandom), 1'($urandom), e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, o, e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        test_reset();
        test_parity_frame();
        test_no_parity();
        test_parity_type();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It latches a parallel byte, serializes it LSB-first, and computes the parity bit. It drives the 2-bit select of the TX output mux so the line carries start, data, parity and stop bits in order. CLK is the TX bit clock (one bit period per cycle); busy is returned to the upstream producer.

Parameters:
DATA_WIDTH, 8, payload bits per frame.

Ports:
CLK  input  1  TX bit clock.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel payload, sampled only when a frame is accepted.
Data_Valid  input  1  request to send P_DATA.
PAR_EN  input  1  1 = append parity bit; sampled with P_DATA.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
mux_sel  output  2  TX mux select: 00 start, 01 stop/idle, 10 serial data, 11 parity.
ser_data  output  1  current payload bit, LSB first.
par_bit  output  1  parity bit of the latched payload.
busy  output  1  high while a frame is on the line.

Behaviour:
- Reset is asynchronous, active-low, and decided: one clock domain only.
- Reset values: state IDLE, mux_sel=01, busy=0, ser_data=0, par_bit=0, bit counter=0, data register=0.
- mux_sel and busy are decoded from the registered state only (Moore), so there are no input-to-output combinational paths.
- States and mux_sel/busy per state:
  - IDLE: mux_sel=01, busy=0.
  - START: mux_sel=00, busy=1.
  - DATA: mux_sel=10, busy=1.
  - PARITY: mux_sel=11, busy=1.
  - STOP: mux_sel=01, busy=1.
- Accept: Data_Valid=1 sampled at a rising edge while in IDLE or STOP.
  - Latch P_DATA into the shift register and latch PAR_EN.
  - par_bit <= ^P_DATA when PAR_TYP=0; par_bit <= ~^P_DATA when PAR_TYP=1.
  - Next state is START.
- Data_Valid in START, DATA or PARITY is ignored. It is not queued and the latched data is not disturbed.
- START to DATA after 1 cycle; the bit counter clears to 0.
- DATA lasts exactly DATA_WIDTH cycles.
  - ser_data = shift register bit 0.
  - The register shifts right each cycle; the counter increments.
  - On counter == DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY to STOP after 1 cycle.
- STOP lasts 1 cycle, then goes to START on an accept, else IDLE.
- Frame length: 1+DATA_WIDTH+1+PAR_EN cycles of busy=1.
- Latency: first START cycle is the cycle immediately after the accepting edge.
- Back-to-back: Data_Valid held through STOP gives a START with no idle cycle between frames.
- PAR_EN, PAR_TYP or P_DATA changing mid-frame has no effect on the current frame.
- Reset asserted mid-frame: outputs go to reset values immediately (line idle high via mux_sel=01) and the frame is aborted. After release the block waits in IDLE for a new Data_Valid.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset: hold RST=0 with Data_Valid=1 -> mux_sel=01, busy=0, par_bit=0 throughout; after release, a new accept starts a frame normally.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid pulse -> 11 busy cycles.
   - mux_sel sequence: 00, 10 x8 (ser_data 1,0,1,0,0,1,0,1), 11, 01.
   - par_bit=0; then IDLE with busy=0.
3. P_DATA=0x01, PAR_EN=0 -> 10-cycle frame: 00, 10 x8 (ser_data 1,0,0,0,0,0,0,0), 01; mux_sel never 11.
4. P_DATA=0x07, PAR_EN=1:
   - PAR_TYP=1 -> par_bit=0 in the PARITY cycle.
   - Repeat with PAR_TYP=0 -> par_bit=1.
   - Toggling PAR_TYP mid-frame leaves par_bit unchanged.
5. Frame 0x3C, then Data_Valid=1 with P_DATA=0xFF pulsed in DATA bit 3 and held through STOP with P_DATA=0x81.
   - 0x3C frame is intact; the 0xFF pulse is ignored.
   - START follows STOP directly and the next payload is 0x81.
6. Assert RST during DATA bit 4 of a 0xF0 frame -> mux_sel=01 and busy=0 in the same cycle; after release, IDLE is held until the next Data_Valid.
